// File: rtl/ram_prog_pkg.sv
// Shared types and constants for the RAM programming sequencer.
// Holds the sequencer state encoding and the default RAM geometry.
package ram_prog_pkg;

    localparam int RAM_DEPTH             = 16;
    localparam int DEFAULT_ADDR_W        = 4;
    localparam int DEFAULT_DATA_W        = 8;
    localparam int DEFAULT_SETUP_CYCLES  = 1;
    localparam int DEFAULT_STROBE_CYCLES = 1;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_BYTE,
        SETUP,
        STROBE,
        HOLD,
        FINISH,
        VERIFY_ADDR,
        VERIFY_READ,
        DONE
    } state_t;

    // A program image must hold at least one byte and fit in the RAM.
    function automatic bit length_legal(input int len, input int depth);
        return (len >= 1) && (len <= depth);
    endfunction

endpackage

// File: rtl/ram_prog_strobe_timer.sv
// Down-counter that times the SETUP and STROBE phases of one RAM write.
// Loading value N makes expired rise after N cycles in the loaded phase.
module ram_prog_strobe_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ram_programmer.sv
// Sequencer that streams a byte image into the RAM manual-programming port.
// Define RAM_PROGRAMMER_VERIFY_EN to add read-back verification over the CPU bus.
module ram_programmer
    import ram_prog_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int SETUP_CYCLES  = DEFAULT_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              program_mode,
    output logic [ADDR_W-1:0] addr_in_manual,
    output logic [DATA_W-1:0] data_in_manual,
    output logic              load_manual,
    output logic              busy,
    output logic              done,
    output logic              error,
`ifdef RAM_PROGRAMMER_VERIFY_EN
    output logic [ADDR_W-1:0] addr_in,
    output logic              addr_en,
    output logic              dataout_en,
    input  logic [DATA_W-1:0] bus_data,
`endif
    output state_t            state_dbg
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t          state;
    logic [ADDR_W:0] remaining;
    logic            timer_load;
    logic [CNT_W-1:0] timer_value;
    logic            timer_expired;

`ifdef RAM_PROGRAMMER_VERIFY_EN
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] shadow [DEPTH];
`endif

    // Byte handshake: byte_ready is high only in WAIT_BYTE, and a byte is
    // transferred on a rising clk edge where byte_valid && byte_ready.
    assign timer_load  = ((state == WAIT_BYTE) && byte_valid && byte_ready) ||
                         ((state == SETUP) && timer_expired);
    assign timer_value = (state == WAIT_BYTE) ? CNT_W'(SETUP_CYCLES) : CNT_W'(STROBE_CYCLES);

    ram_prog_strobe_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .clr        (clr),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state          <= IDLE;
            remaining      <= '0;
            byte_ready     <= 1'b0;
            program_mode   <= 1'b0;
            addr_in_manual <= '0;
            data_in_manual <= '0;
            load_manual    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
`ifdef RAM_PROGRAMMER_VERIFY_EN
            len_q          <= '0;
            addr_in        <= '0;
            addr_en        <= 1'b0;
            dataout_en     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length_legal(int'(length), DEPTH)) begin
                            error          <= 1'b0;
                            addr_in_manual <= '0;
                            remaining      <= length;
                            program_mode   <= 1'b1;
                            byte_ready     <= 1'b1;
                            busy           <= 1'b1;
                            state          <= WAIT_BYTE;
`ifdef RAM_PROGRAMMER_VERIFY_EN
                            len_q          <= length;
`endif
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                WAIT_BYTE: begin
                    if (byte_valid && byte_ready) begin
                        data_in_manual <= byte_data;
                        byte_ready     <= 1'b0;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_expired) begin
                        load_manual <= 1'b1;
                        state       <= STROBE;
                    end
                end
                STROBE: begin
                    if (timer_expired) begin
                        load_manual <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    remaining <= remaining - (ADDR_W+1)'(1);
                    if (remaining == (ADDR_W+1)'(1)) begin
                        state <= FINISH;
                    end else begin
                        // Address moves only here, while load_manual is low.
                        addr_in_manual <= addr_in_manual + ADDR_W'(1);
                        byte_ready     <= 1'b1;
                        state          <= WAIT_BYTE;
                    end
                end
                FINISH: begin
                    program_mode <= 1'b0;
`ifdef RAM_PROGRAMMER_VERIFY_EN
                    addr_in <= '0;
                    addr_en <= 1'b1;
                    state   <= VERIFY_ADDR;
`else
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
`endif
                end
`ifdef RAM_PROGRAMMER_VERIFY_EN
                VERIFY_ADDR: begin
                    addr_en    <= 1'b0;
                    dataout_en <= 1'b1;
                    state      <= VERIFY_READ;
                end
                VERIFY_READ: begin
                    dataout_en <= 1'b0;
                    if (bus_data != shadow[addr_in]) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if ({1'b0, addr_in} == len_q - (ADDR_W+1)'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        addr_in <= addr_in + ADDR_W'(1);
                        addr_en <= 1'b1;
                        state   <= VERIFY_ADDR;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_PROGRAMMER_VERIFY_EN
    // Shadow copy of the image, compared against the RAM during read-back.
    always_ff @(posedge clk) begin
        if ((state == WAIT_BYTE) && byte_valid && byte_ready) begin
            shadow[addr_in_manual] <= byte_data;
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_ram_programmer.sv
// Directed-plus-random bench for ram_programmer with a byte-image RAM model.
// Writes observed on the manual port are scored against the image queue.
module tb_ram_programmer;
    import ram_prog_pkg::*;

    localparam int ADDR_W        = 4;
    localparam int DATA_W        = 8;
    localparam int SETUP_CYCLES  = 1;
    localparam int STROBE_CYCLES = 1;
    localparam int DEPTH         = 16;

    logic              clk;
    logic              clr;
    logic              start;
    logic [ADDR_W:0]   length;
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic              byte_ready;
    logic              program_mode;
    logic [ADDR_W-1:0] addr_in_manual;
    logic [DATA_W-1:0] data_in_manual;
    logic              load_manual;
    logic              busy;
    logic              done;
    logic              error;
    state_t            state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] ram_model [DEPTH];
    logic [DATA_W-1:0] gold      [DEPTH];
    logic [DATA_W-1:0] img       [DEPTH];
    logic [DATA_W-1:0] exp_q[$];

    int cyc = 0;
    int last_accept = 0;
    int ready_cnt = 0;
    int load_edges = 0;
    int done_cnt = 0;
    int wr_idx = 0;
    int cur_width = 0;
    int max_addr = 0;
    logic              prev_load = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

`ifdef RAM_PROGRAMMER_VERIFY_EN
    logic [ADDR_W-1:0] addr_in;
    logic              addr_en;
    logic              dataout_en;
    logic [DATA_W-1:0] bus_data;
    logic [ADDR_W-1:0] mar = '0;
    always @(posedge clk) if (addr_en) mar <= addr_in;
    assign bus_data = ram_model[mar];
`endif

    ram_programmer #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .start          (start),
        .length         (length),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .program_mode   (program_mode),
        .addr_in_manual (addr_in_manual),
        .data_in_manual (data_in_manual),
        .load_manual    (load_manual),
        .busy           (busy),
        .done           (done),
        .error          (error),
`ifdef RAM_PROGRAMMER_VERIFY_EN
        .addr_in        (addr_in),
        .addr_en        (addr_en),
        .dataout_en     (dataout_en),
        .bus_data       (bus_data),
`endif
        .state_dbg      (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (byte_ready) ready_cnt++;
        if (byte_valid && byte_ready) last_accept = cyc;
        if (load_manual) begin
            if (!prev_load) begin
                load_edges++;
                cur_width = 1;
                ram_model[addr_in_manual] = data_in_manual;
                chk("strobe_latency", 32'(cyc - last_accept), 32'(SETUP_CYCLES + 1));
                chk("pm_during_load", 32'(program_mode), 32'd1);
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("write_data", 32'(data_in_manual), 32'(exp_q.pop_front()));
                    chk("write_addr", 32'(addr_in_manual), 32'(wr_idx));
                    wr_idx++;
                end
            end else begin
                cur_width++;
                chk("addr_stable", 32'(addr_in_manual), 32'(prev_addr));
                chk("data_stable", 32'(data_in_manual), 32'(prev_data));
            end
        end else if (prev_load) begin
            chk("strobe_width", 32'(cur_width), 32'(STROBE_CYCLES));
        end
        if (done) done_cnt++;
        if (program_mode && int'(addr_in_manual) > max_addr) max_addr = int'(addr_in_manual);
        prev_load = load_manual;
        prev_addr = addr_in_manual;
        prev_data = data_in_manual;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b);
        int budget;
        byte_valid = 1'b1;
        byte_data  = b;
        budget = 0;
        while (!byte_ready && budget < 200) begin
            tick();
            budget++;
        end
        chk("byte_accepted", 32'(byte_ready), 32'd1);
        tick();
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) img[i] = DATA_W'($urandom);
    endtask

    task automatic run_prog(input int len, input int stall_idx, input int stall_len, input bit poke_start);
        int le0, d0, r0, budget;
        exp_q.delete();
        wr_idx   = 0;
        max_addr = 0;
        le0 = load_edges;
        d0  = done_cnt;
        r0  = ready_cnt;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(img[i]);
            gold[i] = img[i];
        end
        do_start((ADDR_W+1)'(len));
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("error_cleared", 32'(error), 32'd0);
        for (int i = 0; i < len; i++) begin
            if (i == stall_idx && stall_len > 0) begin
                byte_valid = 1'b0;
                repeat (stall_len) tick();
                if (poke_start) begin
                    start  = 1'b1;
                    length = '0;
                    tick();
                    start  = 1'b0;
                    chk("start_ignored_err", 32'(error), 32'd0);
                end
                chk("stall_state", 32'(state_dbg), 32'(WAIT_BYTE));
                chk("stall_load", 32'(load_manual), 32'd0);
                chk("stall_ready", 32'(byte_ready), 32'd1);
            end
            send_byte(img[i]);
        end
        byte_valid = 1'b0;
        budget = 0;
        while (done_cnt == d0 && budget < 150) begin
            tick();
            budget++;
        end
        repeat (3) tick();
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("load_edges", 32'(load_edges - le0), 32'(len));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("pm_after", 32'(program_mode), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("error_after", 32'(error), 32'd0);
        chk("state_after", 32'(state_dbg), 32'(IDLE));
        chk("max_addr", 32'(max_addr), 32'(len - 1));
        if (stall_len == 0) chk("ready_cycles", 32'(ready_cnt - r0), 32'(len));
        for (int k = 0; k < DEPTH; k++) chk($sformatf("ram[%0d]", k), 32'(ram_model[k]), 32'(gold[k]));
    endtask

    initial begin
        int le0, len, sidx, slen, budget;
        for (int k = 0; k < DEPTH; k++) begin
            ram_model[k] = '0;
            gold[k]      = '0;
        end
        clr = 1'b1; start = 1'b0; length = '0; byte_valid = 1'b0; byte_data = '0;
        #3;
        chk("rst_program_mode", 32'(program_mode), 32'd0);
        chk("rst_load_manual", 32'(load_manual), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(addr_in_manual), 32'd0);
        chk("rst_data", 32'(data_in_manual), 32'd0);
        tick(); tick();
        clr = 1'b0;
        tick();

        // Two fixed bytes
        img[0] = 8'h0a; img[1] = 8'h1b;
        run_prog(2, -1, 0, 1'b0);

        // Full RAM with byte_valid held high
        for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(i);
        run_prog(16, -1, 0, 1'b0);

        // Illegal lengths
        le0 = load_edges;
        do_start(5'd0);
        chk("len0_error", 32'(error), 32'd1);
        chk("len0_pm", 32'(program_mode), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("len0_state", 32'(state_dbg), 32'(IDLE));
        do_start(5'd17);
        chk("len17_error", 32'(error), 32'd1);
        chk("len17_pm", 32'(program_mode), 32'd0);
        repeat (3) tick();
        chk("illegal_no_load", 32'(load_edges - le0), 32'd0);
        chk("error_sticky", 32'(error), 32'd1);

        // Stall before second byte, with a start poke while busy
        fill_random(3);
        run_prog(3, 1, 10, 1'b1);

        // Random images, lengths and stalls
        for (int r = 0; r < 4; r++) begin
            len  = $urandom_range(1, 16);
            sidx = $urandom_range(0, len - 1);
            slen = ($urandom_range(0, 1) == 1) ? $urandom_range(4, 8) : 0;
            fill_random(len);
            run_prog(len, sidx, slen, 1'b0);
        end

        // Asynchronous reset during the first strobe
        exp_q.delete();
        wr_idx = 0;
        do_start(5'd4);
        byte_valid = 1'b1;
        byte_data  = DATA_W'($urandom);
        exp_q.push_back(byte_data);
        budget = 0;
        while (!load_manual && budget < 20) begin
            tick();
            byte_valid = 1'b0;
            budget++;
        end
        chk("strobe_reached", 32'(load_manual), 32'd1);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_load_drop", 32'(load_manual), 32'd0);
        chk("clr_pm_drop", 32'(program_mode), 32'd0);
        chk("clr_ready_drop", 32'(byte_ready), 32'd0);
        chk("clr_busy_drop", 32'(busy), 32'd0);
        tick();
        clr = 1'b0;
        tick();
        chk("clr_state_idle", 32'(state_dbg), 32'(IDLE));
        chk("clr_pm_idle", 32'(program_mode), 32'd0);

        // Recovery after reset
        fill_random(5);
        run_prog(5, -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
